// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the ripple adder and serial subtractor paths.
package arith_pkg;

  localparam int unsigned ARITH_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one full-subtractor cell, LSB first, WIDTH cycles per operation.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] d_sh_q, d_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] d_full;

  full_subtractor u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // The last result bit goes straight to diff, so the shift register is one bit short.
  assign d_full = {cell_d, d_sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = ST_RUN;
          busy_d   = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        d_sh_d   = d_full[WIDTH-1:1];
        borrow_d = cell_bo;
        if (cnt_q == LAST_BIT) begin
          diff_d  = d_full;
          bout_d  = cell_bo;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int total = 0;
  int bad = 0;
  int ndone4 = 0;
  int ndone8 = 0;
  logic [8:0] q4[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (done4) begin
      ndone4++;
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL res4_unexpected: got done with result %0h, expected no done", {bout4, diff4});
      end else begin
        e = q4.pop_front();
        chk("res4", 32'({bout4, diff4}), 32'(e[4:0]));
      end
    end
    if (done8) begin
      ndone8++;
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL res8_unexpected: got done with result %0h, expected no done", {bout8, diff8});
      end else begin
        e = q8.pop_front();
        chk("res8", 32'({bout8, diff8}), 32'(e));
      end
    end
  end

  // Issue one operation on the selected DUT and check the busy/done timing.
  task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input bit midstart);
    int unsigned w;
    logic [4:0] e5;
    logic [8:0] e9;
    w = sel ? 8 : 4;
    @(posedge clk); #1;
    if (sel) begin
      a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
      e9 = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
      q8.push_back(e9);
    end else begin
      a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; start4 = 1'b1;
      e5 = {1'b0, av[3:0]} - {1'b0, bv[3:0]} - {4'd0, bi};
      q4.push_back({4'd0, e5});
    end
    @(posedge clk); #1;
    for (int k = 0; k < int'(w); k++) begin
      chk(sel ? "busy8_run" : "busy4_run", 32'(sel ? busy8 : busy4), 32'd1);
      chk(sel ? "done8_run" : "done4_run", 32'(sel ? done8 : done4), 32'd0);
      if (sel) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        start8 = midstart && (k == 1);
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        start4 = midstart && (k == 1);
      end
      @(posedge clk); #1;
    end
    chk(sel ? "busy8_end" : "busy4_end", 32'(sel ? busy8 : busy4), 32'd0);
    chk(sel ? "done8_end" : "done4_end", 32'(sel ? done8 : done4), 32'd1);
    @(posedge clk); #1;
    chk(sel ? "done8_fall" : "done4_fall", 32'(sel ? done8 : done4), 32'd0);
  endtask

  initial begin
    int nd;
    start4 = 0; bin4 = 0; a4 = '0; b4 = '0;
    start8 = 0; bin8 = 0; a8 = '0; b8 = '0;
    #2;
    chk("reset4", 32'({busy4, done4, bout4, diff4}), 32'd0);
    chk("reset8", 32'({busy8, done8, bout8, diff8}), 32'd0);
    #20 rst_n = 1'b1;

    run_op(0, 8'd9, 8'd3, 1'b0, 0);
    run_op(0, 8'd3, 8'd9, 1'b0, 0);
    run_op(0, 8'd0, 8'd0, 1'b1, 0);
    run_op(0, 8'd15, 8'd15, 1'b0, 0);
    run_op(0, 8'd9, 8'd3, 1'b0, 1);

    // start held high through DONE: second op accepted at E5, done at E9
    @(posedge clk); #1;
    a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back(9'h007);
    @(posedge clk); #1;
    a4 = 4'd2; b4 = 4'd7; bin4 = 1'b1;
    q4.push_back(9'h01A);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("b2b_done", 32'(done4), 32'((k == 4) || (k == 9)));
      chk("b2b_busy", 32'(busy4), 32'((k < 4) || (k >= 5 && k < 9)));
      if (k == 5) start4 = 1'b0;
    end

    // asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy4_pre_rst", 32'(busy4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst4_outputs", 32'({busy4, done4, bout4, diff4}), 32'd0);
    nd = ndone4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst4_no_done", 32'(ndone4), 32'(nd));
    chk("rst4_idle", 32'({busy4, done4, bout4, diff4}), 32'd0);
    run_op(0, 8'd5, 8'd2, 1'b0, 0);

    run_op(1, 8'd200, 8'd201, 1'b0, 0);
    run_op(1, 8'd0, 8'd255, 1'b1, 0);
    run_op(1, 8'd255, 8'd0, 1'b0, 0);

    repeat (20) run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    repeat (20) run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

    repeat (3) @(posedge clk);
    #1;
    chk("sb4_drain", 32'(q4.size()), 32'd0);
    chk("sb8_drain", 32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b - bin` one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's ripple-carry adder path: it trades the adder's combinational ripple for WIDTH cycles of latency and one bit-cell of logic. A start/busy/done handshake sequences it, and its results are held stable for downstream sampling.

## Interface
- `WIDTH`, default 4: operand and result width in bits, ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to begin an operation; sampled only while `busy` = 0.
- `a`  in  WIDTH: minuend, unsigned; latched on the accepted `start`.
- `b`  in  WIDTH: subtrahend, unsigned; latched on the accepted `start`.
- `bin`  in  1: borrow-in; latched on the accepted `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle completion pulse.
- `diff`  out  WIDTH: result register, `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: borrow-out; 1 iff `a < b + bin` (unsigned).

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - `busy` = 0, `done` = 0.
  - `start` = 1 latches `a`, `b` and `bin` into the shift registers and the borrow flop, clears the bit counter, and moves to RUN.
- **RUN:**
  - `busy` = 1.
  - Each edge processes bit i = counter, LSB first, with x = a[i], y = b[i], bi = borrow.
  - The cell computes d = x ^ y ^ bi and bo = (~x & y) | (~(x ^ y) & bi).
  - d shifts into the internal difference register and the borrow flop takes bo.
  - On the edge that processes bit WIDTH-1:
    - `diff` and `bout` output registers load the final values.
    - The state moves to DONE.
- **DONE:**
  - `done` = 1 and `busy` = 0 for exactly one cycle.
  - `start` = 1 in this cycle is accepted exactly as in IDLE and moves to RUN.
  - Otherwise the state moves to IDLE.
- `diff`/`bout` change only on the completion edge and hold until the next completion edge.
- `start` while `busy` = 1 is ignored. Operand changes during RUN have no effect.
- The counter is ceil(log2(WIDTH)) bits wide and does not wrap within an operation.
- **Reset:**
  - Asserting `rst_n` = 0 at any time, including mid-RUN, immediately forces IDLE and clears all outputs.
  - The in-flight operation is discarded and no `done` is produced.

## Timing
- Reset values: `busy` = 0, `done` = 0, `diff` = 0, `bout` = 0.
- Let E0 be the edge that accepts `start`:
  - `busy` is high in the cycles after E0 through E(WIDTH).
  - `diff`, `bout` and `done` are updated at E(WIDTH).
  - `done` falls at E(WIDTH+1).
- Latency is WIDTH edges from acceptance to valid result.
- Maximum throughput is one operation per WIDTH+1 cycles, using back-to-back `start` in DONE.
- No combinational path from inputs to outputs.

## Structure
- The shared package `arith_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant (4), shared with the ripple adder.
- One sub-module, `full_subtractor` (inputs x, y, bin; outputs d, bout), is purely combinational.
  - It mirrors the adder's bit cell and is instantiated once.
- Everything else lives in `serial_subtractor`: the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
- WIDTH=4, a=9, b=3, bin=0, one-cycle `start` → `busy` high 4 cycles; `done` pulse at E4 with `diff` = 6, `bout` = 0.
- WIDTH=4, a=3, b=9, bin=0 → `diff` = 4'hA, `bout` = 1.
- WIDTH=4, a=0, b=0, bin=1 → `diff` = 4'hF, `bout` = 1. Then a=15, b=15, bin=0 → `diff` = 0, `bout` = 0.
- `start` pulsed mid-RUN with different operands → ignored; the first result is unaffected. A `start` held high through DONE → second operation begins at E5, and its `done` arrives at E9.
- `rst_n` asserted at cycle 2 of RUN → all outputs 0 immediately and no `done`. After release, a=5, b=2 → `diff` = 3, `bout` = 0.
- WIDTH=8, a=200, b=201, bin=0 → `diff` = 255, `bout` = 1 after 8 cycles. A random sweep checks `{bout, diff}` against `{1'b0, a} - {1'b0, b} - bin`.
